// File: rtl/alu_pkg.sv
// Shared types for the PISO serializer: FSM state encoding and counter sizing.
// No logic, no latency; imported by the serializer top.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_t;

    localparam int PISO_DEFAULT_WIDTH = 8;

    // Counter width for a frame of `width` bits; never below 1 bit.
    function automatic int piso_cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int PISO_DEFAULT_CNT_W = piso_cnt_w(PISO_DEFAULT_WIDTH);

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Up-counter with synchronous clear and enable, saturating at MAX-1; tc_o flags MAX-1.
// Latency: one cycle from clr_i/en_i to count; no handshake of its own.
module bit_counter #(
    parameter int MAX = 8,
    parameter int CW  = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CW-1:0] LAST = CW'(MAX - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturate rather than wrap so the count never leaves 0..MAX-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out, LSB first; first bit the cycle after load, ser_ready=0 stalls in place.
// Loads accepted only in IDLE; PISO_PARITY_EN appends an even-parity bit carrying ser_last.
module piso_serializer
    import alu_pkg::*;
#(
    parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_data,
    output logic             ser_last
);

    localparam int CW = piso_cnt_w(WIDTH);

`ifdef PISO_PARITY_EN
    localparam piso_state_t AFTER_SHIFT = PARITY;
`else
    localparam piso_state_t AFTER_SHIFT = IDLE;
`endif

    piso_state_t      state_q;
    logic [WIDTH-1:0] shift_q;
    logic             last_bit;
    logic             load_fire;
    logic             shift_xfer;
`ifdef PISO_PARITY_EN
    logic             par_q;
`endif

    assign load_fire  = (state_q == IDLE) && load_valid;
    assign shift_xfer = (state_q == SHIFT) && ser_ready;

    bit_counter #(
        .MAX (WIDTH),
        .CW  (CW)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (reset_n),
        .clr_i (load_fire),
        .en_i  (shift_xfer),
        .tc_o  (last_bit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        shift_q <= load_data;
`ifdef PISO_PARITY_EN
                        par_q   <= ^load_data;
`endif
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ser_ready) begin
                        shift_q <= {1'b0, shift_q[WIDTH-1:1]};
                        if (last_bit) begin
                            state_q <= AFTER_SHIFT;
                        end
                    end
                end
                PARITY: begin
                    if (ser_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // All outputs decode from registered state only: no input-to-output paths.
    assign load_ready = (state_q == IDLE);
    assign ser_valid  = (state_q == SHIFT) || (state_q == PARITY);

    always_comb begin
        ser_data = 1'b0;
        case (state_q)
            SHIFT:   ser_data = shift_q[0];
`ifdef PISO_PARITY_EN
            PARITY:  ser_data = par_q;
`endif
            default: ser_data = 1'b0;
        endcase
    end

`ifdef PISO_PARITY_EN
    assign ser_last = (state_q == PARITY);
`else
    assign ser_last = (state_q == SHIFT) && last_bit;
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: a frame model fills an expected-bit queue on each
// accepted load; a negedge monitor compares every presented serial bit and the handshakes.
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int GAP = W + 1 + (PAR ? 1 : 0);

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [W-1:0] load_data = '0;
    logic         ser_valid;
    logic         ser_ready = 1'b0;
    logic         ser_data;
    logic         ser_last;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accepts = 0;
    int last_acc = -1;
    bit rnd_rdy = 1'b0;
    bit b2b = 1'b0;

    // Expected serial stream: {last, data} per bit, oldest first.
    logic [1:0] expq[$];

    piso_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .ser_data   (ser_data),
        .ser_last   (ser_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Frame model: data bits LSB first, then optional even-parity bit; last flag on final one.
    task automatic model_load(input logic [W-1:0] d);
        int ones = 0;
        for (int i = 0; i < W; i++) begin
            ones += int'(d[i]);
            expq.push_back({(i == W - 1) && !PAR, d[i]});
        end
        if (PAR) expq.push_back({1'b1, 1'(ones % 2)});
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                chk("rst_ser_valid", ser_valid, 0);
                chk("rst_ser_data", ser_data, 0);
                chk("rst_ser_last", ser_last, 0);
                chk("rst_load_ready", load_ready, 1);
                expq.delete();
            end else begin
                chk("load_ready", load_ready, expq.size() == 0);
                chk("ser_valid", ser_valid, expq.size() != 0);
                if (expq.size() == 0) begin
                    chk("idle_ser_data", ser_data, 0);
                    chk("idle_ser_last", ser_last, 0);
                    if (load_valid) begin
                        model_load(load_data);
                        accepts++;
                        if (b2b && last_acc >= 0) chk("b2b_gap", cyc - last_acc, GAP);
                        last_acc = cyc;
                    end
                end else begin
                    chk("ser_data", ser_data, expq[0][0]);
                    chk("ser_last", ser_last, expq[0][1]);
                    if (ser_ready) void'(expq.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) ser_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_load(input logic [W-1:0] d);
        int n = 0;
        while (!load_ready && n < 300) begin
            tick();
            n++;
        end
        chk("load_wait", load_ready, 1);
        load_valid = 1'b1;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(load_ready && expq.size() == 0) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_timeout", int'(load_ready && expq.size() == 0), 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        logic [W-1:0] v;
        #1;
        chk("reset_ready", load_ready, 1);
        chk("reset_valid", ser_valid, 0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Directed frames with ser_ready held high.
        ser_ready = 1'b1;
        do_load(8'hA5);
        wait_idle();
        do_load(8'h07);
        wait_idle();

        // Back-pressure: stall three cycles while bit 2 is presented.
        do_load(8'h3C);
        tick();
        tick();
        ser_ready = 1'b0;
        repeat (3) tick();
        ser_ready = 1'b1;
        wait_idle();

        // Load attempted while busy must be ignored.
        do_load(8'hFF);
        load_valid = 1'b1;
        load_data  = 8'h00;
        tick();
        load_valid = 1'b0;
        wait_idle();

        // Asynchronous reset mid-frame, then a fresh frame.
        do_load(8'h5A);
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_ser_valid", ser_valid, 0);
        chk("midrst_ser_data", ser_data, 0);
        chk("midrst_ser_last", ser_last, 0);
        chk("midrst_load_ready", load_ready, 1);
        tick();
        reset_n = 1'b1;
        tick();
        do_load(8'h81);
        wait_idle();

        // Randomized data and back-pressure, with occasional loads while busy.
        rnd_rdy = 1'b1;
        for (int f = 0; f < 25; f++) begin
            repeat ($urandom_range(0, 3)) tick();
            v = W'($urandom);
            do_load(v);
            if ($urandom_range(0, 1) == 1) begin
                load_valid = 1'b1;
                load_data  = W'($urandom);
                tick();
                load_valid = 1'b0;
            end
        end
        wait_idle();

        // Back-to-back: load_valid held high, ser_ready held high.
        rnd_rdy   = 1'b0;
        ser_ready = 1'b1;
        b2b       = 1'b1;
        last_acc  = -1;
        accepts   = 0;
        load_valid = 1'b1;
        for (int c = 0; c < 6 * GAP; c++) begin
            load_data = W'($urandom);
            tick();
        end
        load_valid = 1'b0;
        chk("b2b_accepts", int'(accepts >= 5), 1);
        b2b = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out converter that accepts a WIDTH-bit word over a valid/ready load handshake and emits it one bit per accepted serial transfer, LSB first. It is the read-out counterpart of the datapath's parallel registers. It sits between a register or ALU result and any bit-serial consumer, such as a link, a debug port or a serial checker. Frame boundaries are marked by ser_last.

## Interface
Parameters:
- WIDTH, 8, data word width in bits; must be ≥ 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  parallel word to serialize.
- ser_valid  output  1  ser_data carries a valid bit.
- ser_ready  input  1  consumer accepts ser_data this cycle.
- ser_data  output  1  current serial bit.
- ser_last  output  1  current bit is the final bit of the frame.

## Operation
- **States:** IDLE, SHIFT, and PARITY (PARITY exists only with the macro, see Configuration).
- **Outputs per state:**
  - load_ready = 1 only in IDLE; it is decoded combinationally from state.
  - ser_valid = 1 in SHIFT and PARITY.
  - ser_data = shift-register bit 0 in SHIFT, the stored parity bit in PARITY, and 0 in IDLE.
- **Load:** IDLE with load_valid=1 at an edge:
  - shift register ← load_data;
  - bit counter ← 0;
  - go to SHIFT.
- **Load while busy:** load_valid in SHIFT or PARITY is ignored; no data is captured.
- **Transfer:** occurs when ser_valid && ser_ready at an edge.
  - In SHIFT: shift register shifts right by 1 (MSB filled with 0); counter increments.
  - The transfer with counter = WIDTH-1 ends SHIFT and goes to PARITY if enabled, else IDLE.
  - The transfer in PARITY goes to IDLE.
- **Stall:** ser_ready=0 holds ser_data, ser_last, the counter and the state unchanged.
- **ser_last:** 1 when the counter = WIDTH-1 in SHIFT with parity disabled, or in PARITY when parity is enabled; otherwise 0.
- **Counter:** width $clog2(WIDTH); it never exceeds WIDTH-1, so it does not wrap.
- **Reset (async, any time, including mid-frame):**
  - state → IDLE; shift register, counter and parity → 0;
  - ser_valid=0, ser_data=0, ser_last=0, load_ready=1 (in reset and on release);
  - the partial frame is discarded and is not resumed.

## Timing
- Load accepted at edge N → ser_valid=1 with bit 0 from cycle N+1.
- With ser_ready held high:
  - a frame occupies WIDTH cycles (WIDTH+1 with parity);
  - load_ready returns to 1 the cycle after the last transfer;
  - minimum spacing between load accepts is WIDTH+1 cycles (WIDTH+2 with parity).
- No combinational path from ser_ready to load_ready, or from load_valid to any output.

## Configuration
- Macro: PISO_PARITY_EN.
- **Defined:**
  - even parity (XOR of load_data) is captured at load;
  - it is sent as one extra bit after data bit WIDTH-1, in state PARITY;
  - ser_last asserts on the parity bit.
- **Undefined:**
  - no PARITY state and no parity register;
  - ser_last asserts on data bit WIDTH-1.

## Structure
- Shared package alu_pkg holds:
  - the state enum piso_state_t (IDLE, SHIFT, PARITY);
  - the counter-width helper constant derived from WIDTH.
- One sub-module, bit_counter: a parameterized up-counter with clear and enable, active-low asynchronous reset, and a terminal-count output at WIDTH-1.
- Shift register, parity bit and FSM live in piso_serializer.

## Test plan
- **Basic frame:** load 8'hA5 with ser_ready=1.
  - ser_data = 1,0,1,0,0,1,0,1 over 8 cycles;
  - ser_last on the 8th bit;
  - load_ready=1 in cycle 9.
- **Back-pressure:** load 8'h3C; drop ser_ready for 3 cycles after bit 2.
  - ser_data holds 1 and the counter is frozen during the stall;
  - the full sequence 0,0,1,1,1,1,0,0 completes with no bit lost or duplicated.
- **Busy-load rejection:** load 8'hFF, then pulse load_valid with 8'h00 during SHIFT.
  - eight 1s are emitted;
  - 8'h00 is never seen.
- **Mid-frame reset:** assert reset_n=0 after 3 bits of 8'h5A.
  - ser_valid, ser_data and ser_last go 0 immediately;
  - load_ready=1;
  - a subsequent load of 8'h81 serializes as 1,0,0,0,0,0,0,1.
- **Parity (PISO_PARITY_EN):**
  - 8'hA5 → 9th bit 0, with ser_last on it;
  - 8'h07 → 9th bit 1.
- **Back-to-back loads:** with load_valid held high continuously, accepts are spaced exactly WIDTH+1 cycles apart (WIDTH+2 with parity).
